// File: rtl/video_wb_prefetch.sv
// Wishbone burst read master that prefetches one video line into a show-ahead pixel FIFO.
// FIFO space for a whole burst is reserved before the bus cycle opens, so a push can never overflow.
module video_wb_prefetch #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int LEN_W      = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] line_addr,
  input  logic [LEN_W-1:0]  line_len,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic              wb_we_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              pix_rd,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underrun,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT_SPACE, BURST} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remain;
  logic [LEN_W-1:0]  beats;
  logic [LEN_W-1:0]  burst_n;
  logic              cyc;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  free;
  logic [DATA_W-1:0] head_hold;

  logic beat_ack, last_beat, burst_go, push, pop;

  // An ack only counts inside an open cycle, and a new line overrides it.
  assign beat_ack  = cyc && wb_ack_i && !line_start;
  assign last_beat = beat_ack && (beats == LEN_W'(1));
  assign burst_n   = (remain < LEN_W'(BURST_LEN)) ? remain : LEN_W'(BURST_LEN);
  assign free      = CNT_W'(FIFO_DEPTH) - count;
  assign burst_go  = (state == WAIT_SPACE) && !line_start && (remain != '0) &&
                     (32'(free) >= 32'(burst_n));
  assign push      = beat_ack;
  assign pop       = pix_rd && (count != '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next state gets a default before any branch, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    if (line_start) begin
      state_nxt = (line_len != '0) ? WAIT_SPACE : IDLE;
    end else begin
      unique case (state)
        WAIT_SPACE: begin
          if (remain == '0)  state_nxt = IDLE;
          else if (burst_go) state_nxt = BURST;
        end
        BURST:   if (last_beat) state_nxt = WAIT_SPACE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr   <= '0;
      remain <= '0;
      beats  <= '0;
      cyc    <= 1'b0;
    end else if (line_start) begin
      addr   <= line_addr;
      remain <= line_len;
      beats  <= '0;
      cyc    <= 1'b0;
    end else begin
      if (burst_go) begin
        beats <= burst_n;
        cyc   <= 1'b1;
      end
      if (beat_ack) begin
        addr   <= addr + ADDR_W'(1);
        remain <= remain - LEN_W'(1);
        beats  <= beats - LEN_W'(1);
        if (last_beat) cyc <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      underrun  <= 1'b0;
      head_hold <= '0;
    end else begin
      underrun  <= pix_rd && (count == '0);
      head_hold <= pix_data;
      if (line_start) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + PTR_W'(1);
        if (pop)  rptr <= rptr + PTR_W'(1);
        unique case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: the storage array has no reset; entries are only read after being written, and pix_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wb_dat_i;
  end

  assign pix_valid = (count != '0);
  assign pix_data  = pix_valid ? mem[rptr] : head_hold;
  assign wb_cyc_o  = cyc;
  assign wb_stb_o  = cyc;
  assign wb_adr_o  = addr;
  assign wb_we_o   = 1'b0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_video_wb_prefetch.sv
// Self-checking bench for video_wb_prefetch: a Wishbone memory slave with optional wait states,
// and an expected pixel stream built from line address/length and a fixed memory content function.
module tb_video_wb_prefetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_start;
  logic [23:0] line_addr;
  logic [11:0] line_len;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [23:0] wb_adr_o;
  logic [7:0]  wb_dat_i;
  logic        wb_ack_i;
  logic        pix_rd;
  logic [7:0]  pix_data;
  logic        pix_valid, underrun, busy;

  int errors = 0;
  int checks = 0;
  int cyc_no = 0;
  int wait_max = 0;
  bit stray = 1'b0;

  typedef struct {
    logic [23:0] adr;
    int          cyc;
  } beat_t;

  beat_t      beats_q[$];
  logic [7:0] exp_q[$];

  video_wb_prefetch dut (
    .clk(clk), .rst_n(rst_n),
    .line_start(line_start), .line_addr(line_addr), .line_len(line_len),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_adr_o(wb_adr_o), .wb_we_o(wb_we_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .pix_rd(pix_rd), .pix_data(pix_data), .pix_valid(pix_valid),
    .underrun(underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc_no++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] mem_word(input logic [23:0] a);
    return a[7:0] + a[15:8] * 8'd3 + a[23:16] * 8'd5 + 8'h3C;
  endfunction

  // Memory slave: decides the ack for the coming edge just after each falling edge.
  initial begin
    int wt;
    bit in_beat;
    wt = 0;
    in_beat = 1'b0;
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(negedge clk);
      #1;
      wb_ack_i = 1'b0;
      if (rst_n && wb_cyc_o && wb_stb_o) begin
        if (!in_beat) begin
          in_beat = 1'b1;
          wt = int'($urandom_range(wait_max, 0));
        end
        if (wt == 0) begin
          wb_ack_i = 1'b1;
          wb_dat_i = mem_word(wb_adr_o);
          in_beat  = 1'b0;
          if (!line_start) beats_q.push_back('{wb_adr_o, cyc_no});
        end else begin
          wt--;
        end
      end else begin
        in_beat = 1'b0;
        if (stray) begin
          wb_ack_i = 1'b1;
          wb_dat_i = 8'hEE;
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge one cycle later.
  task automatic start_line(input logic [23:0] base, input int len);
    logic [23:0] a;
    beats_q.delete();
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      a = base + 24'(i);
      exp_q.push_back(mem_word(a));
    end
    line_start = 1'b1;
    line_addr  = base;
    line_len   = 12'(len);
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int t = 0;
    while (busy !== 1'b0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%b after %0d cycles, want 0", name, busy, budget);
    end
  endtask

  // Pops n pixels (randomly gated if rnd) and compares each against the expected stream.
  task automatic drain(input int n, input int budget, input bit rnd, input string name);
    int got = 0;
    int t = 0;
    logic [7:0] exp;
    while (got < n && t < budget) begin
      pix_rd = 1'b0;
      if (pix_valid === 1'b1 && (!rnd || $urandom_range(1, 0) == 1)) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (pix_data !== exp) begin
          errors++;
          $display("FAIL %s: pixel %0d got %h want %h", name, got, pix_data, exp);
        end
        pix_rd = 1'b1;
        got++;
      end
      @(negedge clk);
      t++;
    end
    pix_rd = 1'b0;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s: popped %0d pixels, want %0d", name, got, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    line_start = 1'b0;
    line_addr = '0;
    line_len = '0;
    pix_rd = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, pix_valid, underrun, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: cyc/stb/we/valid/underrun/busy=%b want 000000",
               {wb_cyc_o, wb_stb_o, wb_we_o, pix_valid, underrun, busy});
    end
    checks++;
    if (wb_adr_o !== 24'h0 || pix_data !== 8'h0) begin
      errors++;
      $display("FAIL reset_data: adr=%h pix_data=%h want 0", wb_adr_o, pix_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wb_cyc_o !== 1'b0 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b cyc=%b valid=%b want 0", busy, wb_cyc_o, pix_valid);
    end
  endtask

  task automatic test_basic_line();
    int c0;
    int want_cyc;
    wait_max = 0;
    @(negedge clk);
    c0 = cyc_no;
    start_line(24'h000100, 8);
    checks++;
    if (wb_cyc_o !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_wait: cyc=%b busy=%b want 0,1", wb_cyc_o, busy);
    end
    @(negedge clk);
    checks++;
    if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 || wb_adr_o !== 24'h000100) begin
      errors++;
      $display("FAIL basic_first: cyc=%b stb=%b adr=%h want 1,1,000100", wb_cyc_o, wb_stb_o, wb_adr_o);
    end
    wait_idle(50, "basic_idle");
    checks++;
    if (cyc_no != c0 + 12) begin
      errors++;
      $display("FAIL basic_idle_cycle: idle in cycle %0d want %0d", cyc_no - c0, 12);
    end
    checks++;
    if (beats_q.size() != 8) begin
      errors++;
      $display("FAIL basic_beats: %0d beats want 8", beats_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        want_cyc = c0 + 2 + i + ((i >= 4) ? 1 : 0);
        checks++;
        if (beats_q[i].adr !== 24'h000100 + 24'(i) || beats_q[i].cyc != want_cyc) begin
          errors++;
          $display("FAIL basic_beat%0d: adr=%h cyc=%0d want %h cyc=%0d", i,
                   beats_q[i].adr, beats_q[i].cyc - c0, 24'h000100 + 24'(i), want_cyc - c0);
        end
      end
    end
    drain(8, 20, 1'b0, "basic_data");
    checks++;
    if (pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_empty: pix_valid=%b want 0", pix_valid);
    end
  endtask

  task automatic test_underrun();
    @(negedge clk);
    pix_rd = 1'b1;
    @(negedge clk);
    pix_rd = 1'b0;
    checks++;
    if (underrun !== 1'b1 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL underrun_pulse: underrun=%b valid=%b want 1,0", underrun, pix_valid);
    end
    @(negedge clk);
    checks++;
    if (underrun !== 1'b0 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clear: underrun=%b valid=%b want 0,0", underrun, pix_valid);
    end
  endtask

  task automatic test_stray_ack();
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b0 || wb_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack: valid=%b busy=%b cyc=%b want 0,0,0", pix_valid, busy, wb_cyc_o);
    end
  endtask

  task automatic test_backpressure();
    int t;
    wait_max = 0;
    @(negedge clk);
    start_line(24'h004000, 40);
    repeat (40) @(negedge clk);
    checks++;
    if (beats_q.size() != 16 || wb_cyc_o !== 1'b0 || busy !== 1'b1 || pix_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: beats=%0d cyc=%b busy=%b valid=%b want 16,0,1,1",
               beats_q.size(), wb_cyc_o, busy, pix_valid);
    end
    drain(3, 10, 1'b0, "bp_pop3");
    repeat (6) @(negedge clk);
    checks++;
    if (beats_q.size() != 16 || wb_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: beats=%0d cyc=%b want 16,0", beats_q.size(), wb_cyc_o);
    end
    drain(1, 10, 1'b0, "bp_pop4");
    t = 0;
    while (wb_cyc_o !== 1'b1 && t < 3) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (wb_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_resume: cyc=%b after %0d cycles want 1", wb_cyc_o, t);
    end
    drain(36, 600, 1'b0, "bp_data");
    wait_idle(20, "bp_idle");
    checks++;
    if (beats_q.size() != 40) begin
      errors++;
      $display("FAIL bp_beats: %0d beats want 40", beats_q.size());
    end else begin
      for (int i = 0; i < 40; i++) begin
        checks++;
        if (beats_q[i].adr !== 24'h004000 + 24'(i)) begin
          errors++;
          $display("FAIL bp_adr%0d: adr=%h want %h", i, beats_q[i].adr, 24'h004000 + 24'(i));
        end
      end
    end
  endtask

  task automatic test_short_tail();
    logic [23:0] base;
    wait_max = 0;
    base = 24'($urandom_range(24'hFFF000, 0));
    @(negedge clk);
    start_line(base, 6);
    wait_idle(40, "tail_idle");
    checks++;
    if (beats_q.size() != 6) begin
      errors++;
      $display("FAIL tail_beats: %0d beats want 6", beats_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (beats_q[i].adr !== base + 24'(i)) begin
          errors++;
          $display("FAIL tail_adr%0d: adr=%h want %h", i, beats_q[i].adr, base + 24'(i));
        end
      end
      checks++;
      if (beats_q[4].cyc - beats_q[3].cyc != 2 || beats_q[5].cyc - beats_q[4].cyc != 1) begin
        errors++;
        $display("FAIL tail_split: gaps %0d,%0d want 2,1",
                 beats_q[4].cyc - beats_q[3].cyc, beats_q[5].cyc - beats_q[4].cyc);
      end
    end
    drain(6, 20, 1'b0, "tail_data");
  endtask

  task automatic test_wrap();
    logic [23:0] want [4];
    want = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
    wait_max = 0;
    @(negedge clk);
    start_line(24'hFFFFFE, 4);
    wait_idle(30, "wrap_idle");
    checks++;
    if (beats_q.size() != 4) begin
      errors++;
      $display("FAIL wrap_beats: %0d beats want 4", beats_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (beats_q[i].adr !== want[i]) begin
          errors++;
          $display("FAIL wrap_adr%0d: adr=%h want %h", i, beats_q[i].adr, want[i]);
        end
      end
    end
    drain(4, 20, 1'b0, "wrap_data");
  endtask

  task automatic test_abort();
    int t;
    wait_max = 0;
    @(negedge clk);
    start_line(24'h002000, 8);
    t = 0;
    while (beats_q.size() != 1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (beats_q.size() != 1 || wb_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_setup: beats=%0d cyc=%b want 1,1", beats_q.size(), wb_cyc_o);
    end
    start_line(24'h003000, 5);
    checks++;
    if (wb_cyc_o !== 1'b0 || pix_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_drop: cyc=%b valid=%b busy=%b want 0,0,1", wb_cyc_o, pix_valid, busy);
    end
    wait_idle(40, "abort_idle");
    checks++;
    if (beats_q.size() != 5 || beats_q[0].adr !== 24'h003000) begin
      errors++;
      $display("FAIL abort_refetch: beats=%0d first adr=%h want 5,003000",
               beats_q.size(), (beats_q.size() != 0) ? beats_q[0].adr : 24'hx);
    end
    drain(5, 20, 1'b0, "abort_data");
  endtask

  task automatic test_random_waits();
    logic [23:0] base;
    int len;
    wait_max = 3;
    for (int l = 0; l < 3; l++) begin
      base = 24'($urandom);
      len  = int'($urandom_range(50, 20));
      @(negedge clk);
      start_line(base, len);
      drain(len, 3000, 1'b1, "rand_data");
      wait_idle(20, "rand_idle");
      checks++;
      if (beats_q.size() != len) begin
        errors++;
        $display("FAIL rand_beats: %0d beats want %0d", beats_q.size(), len);
      end else begin
        for (int i = 0; i < len; i++) begin
          checks++;
          if (beats_q[i].adr !== base + 24'(i)) begin
            errors++;
            $display("FAIL rand_adr%0d: adr=%h want %h", i, beats_q[i].adr, base + 24'(i));
          end
        end
      end
    end
    wait_max = 0;
  endtask

  task automatic test_reset_mid_burst();
    wait_max = 0;
    @(negedge clk);
    start_line(24'h005000, 16);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || pix_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: cyc=%b stb=%b valid=%b busy=%b want 0", wb_cyc_o, wb_stb_o, pix_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (wb_cyc_o !== 1'b0 || pix_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: cyc=%b valid=%b busy=%b want 0", wb_cyc_o, pix_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_line();
    test_underrun();
    test_stray_ack();
    test_backpressure();
    test_short_tail();
    test_wrap();
    test_abort();
    test_random_waits();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
